// File: rtl/dma_csr_seq.sv
// dma_csr_seq: in-order AXI-Lite CSR master fed by a small command FIFO, with response watchdog.
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_cmd_* / o_cmd_ready              command push (write flag, addr, wdata, wstrb)
//   o_rsp_* / i_rsp_ready              one response per command (type echo, rdata, resp)
//   AW/W/B/AR/R                        AXI-Lite master channels (ids constant, prot 0)
//   o_busy                             sequencer active or commands queued
//   o_hang                             sticky watchdog flag, cleared only by reset
module dma_csr_seq #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int TXN_ID      = 0,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ID_WIDTH-1:0]     o_awid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [2:0]              o_awprot,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [ID_WIDTH-1:0]     i_bid,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ID_WIDTH-1:0]     o_arid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic [2:0]              o_arprot,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [ID_WIDTH-1:0]     i_rid,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  output logic                    o_busy,
  output logic                    o_hang
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int WDW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP, HUNG} state_t;
  logic                  f_write_q [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] f_addr_q  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] f_wdata_q [CMD_DEPTH];
  logic [SW-1:0]         f_wstrb_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop, timeout;
  state_t state_q;
  logic [WDW-1:0] wd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;
  logic [SW-1:0] wstrb_q;
  logic [1:0] rsp_resp_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q, rsp_write_q, hang_q;
  logic unused_ids;
  assign unused_ids = ^{i_bid, i_rid};
  // Depth is a power of two, so the count MSB alone means full.
  assign o_cmd_ready = !cnt_q[AW] && !hang_q;
  assign push = i_cmd_valid && o_cmd_ready;
  assign pop = state_q == IDLE && cnt_q != '0;
  assign cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign timeout = TIMEOUT_CYC != 0 && wd_q == WD_LAST;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      f_write_q[wr_ptr_q] <= i_cmd_write;
      f_addr_q[wr_ptr_q]  <= i_cmd_addr;
      f_wdata_q[wr_ptr_q] <= i_cmd_wdata;
      f_wstrb_q[wr_ptr_q] <= i_cmd_wstrb;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      hang_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          addr_q      <= f_addr_q[rd_ptr_q];
          wdata_q     <= f_wdata_q[rd_ptr_q];
          wstrb_q     <= f_wstrb_q[rd_ptr_q];
          rsp_write_q <= f_write_q[rd_ptr_q];
          awvalid_q   <= f_write_q[rd_ptr_q];
          wvalid_q    <= f_write_q[rd_ptr_q];
          arvalid_q   <= !f_write_q[rd_ptr_q];
          state_q     <= f_write_q[rd_ptr_q] ? WR_ADDR : RD_ADDR;
        end
        WR_ADDR: begin
          // AW and W retire independently; move on once neither is still pending.
          if (i_awready) awvalid_q <= 1'b0;
          if (i_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
            bready_q <= 1'b1;
            wd_q     <= '0;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (i_bvalid) begin
          rsp_resp_q  <= i_bresp;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          bready_q    <= 1'b0;
          state_q     <= RSP;
        end else if (timeout) begin
          bready_q <= 1'b0;
          hang_q   <= 1'b1;
          state_q  <= HUNG;
        end else wd_q <= wd_q + 1'b1;
        RD_ADDR: if (i_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          wd_q      <= '0;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (i_rvalid) begin
          rsp_resp_q  <= i_rresp;
          rsp_rdata_q <= i_rdata;
          rsp_valid_q <= 1'b1;
          rready_q    <= 1'b0;
          state_q     <= RSP;
        end else if (timeout) begin
          rready_q <= 1'b0;
          hang_q   <= 1'b1;
          state_q  <= HUNG;
        end else wd_q <= wd_q + 1'b1;
        RSP: if (i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        HUNG: state_q <= HUNG;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_awvalid   = awvalid_q;
  assign o_awid      = ID_WIDTH'(TXN_ID);
  assign o_awaddr    = addr_q;
  assign o_awprot    = 3'b000;
  assign o_wvalid    = wvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_bready    = bready_q;
  assign o_arvalid   = arvalid_q;
  assign o_arid      = ID_WIDTH'(TXN_ID);
  assign o_araddr    = addr_q;
  assign o_arprot    = 3'b000;
  assign o_rready    = rready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
  assign o_busy      = state_q != IDLE || cnt_q != '0;
  assign o_hang      = hang_q;
endmodule
